// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter slice.
//   arb_state_t : arbiter FSM encoding (IDLE, WAIT_BUSY, WAIT_DONE, HOLD)
//   UART_BYTE_W : width of one UART payload byte
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector.
// Searches req upward (cyclically) starting one position above rr_ptr, so the
// requester at rr_ptr has the lowest priority.
// Ports:
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  ID_W     index of the most recent owner
//   winner    out ID_W     selected index (0 when nothing requests)
//   any_valid out 1        at least one request bit is set
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic [ID_W:0]        start;
  logic [2*NUM_REQ-1:0] dbl;
  int                   sum;

  // Rotate the request vector so bit 0 is the first candidate after rr_ptr;
  // the lowest set bit of the rotated vector is then the winner.
  always_comb begin
    start  = {1'b0, rr_ptr} + (ID_W+1)'(1);
    dbl    = {req, req} >> start;
    winner = '0;
    sum    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        sum = int'(start) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        winner = ID_W'(sum);
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx byte transmitter
// between NUM_REQ valid/ready byte sources. An owner keeps the transmitter
// across a multi-byte packet until it presents a byte flagged req_last.
// Optional build macro: UART_ARB_TIMEOUT_EN adds an abort counter for
// WAIT_BUSY/HOLD and the err_timeout port.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    in  NUM_REQ    per-requester byte valid
//   req_data     in  NUM_REQ*8  requester i at bits [8i+7:8i]
//   req_last     in  NUM_REQ    final byte of packet (sampled on accept)
//   req_ready    out NUM_REQ    combinational accept strobe, one-hot or zero
//   tx_start     out 1          one-cycle start pulse to uart_tx
//   tx_data      out 8          byte to uart_tx, stable until frame done
//   tx_busy      in  1          busy flag from uart_tx
//   grant_valid  out 1          transmitter currently owned
//   grant_id     out ID_W       owner index
//   err_timeout  out 1          one-cycle abort pulse (macro builds only)
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic                           grant_valid,
  output logic [ID_W-1:0]                grant_id
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                           err_timeout
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arb: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        acc_id;
  logic [UART_BYTE_W-1:0] acc_byte;
  logic                   acc_last;
  logic                   any_valid;
  logic                   accept;
  logic                   last_q;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Accept decode. Ready is gated by rst so it drops together with the
  // asynchronously cleared state. In IDLE a still-busy transmitter (reset
  // skew) blocks the accept; in HOLD only the owner may continue.
  always_comb begin
    req_ready = '0;
    acc_id    = winner;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (any_valid && !tx_busy) req_ready[winner] = 1'b1;
        end
        HOLD: begin
          acc_id              = grant_id;
          req_ready[grant_id] = req_valid[grant_id];
        end
        default: ;
      endcase
    end
    acc_byte = '0;
    acc_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == acc_id) begin
        acc_byte = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        acc_last = req_last[i];
      end
    end
  end

  assign accept = |req_ready;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOUT_W-1:0] tout_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      last_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tout_cnt    <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            tx_data     <= acc_byte;
            tx_start    <= 1'b1;
            grant_valid <= 1'b1;
            grant_id    <= acc_id;
            last_q      <= acc_last;
            state       <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              state       <= IDLE;
              rr_ptr      <= grant_id;
              grant_valid <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      // The counter only advances while the state is unchanged; any
      // transition (including the abort itself) restarts it from zero.
      err_timeout <= 1'b0;
      tout_cnt    <= '0;
      if ((state == WAIT_BUSY && !tx_busy) || (state == HOLD && !accept)) begin
        if (tout_cnt == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          err_timeout <= 1'b1;
          rr_ptr      <= grant_id;
          grant_valid <= 1'b0;
        end else begin
          tout_cnt <= tout_cnt + TOUT_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb with four requesters and
// a simple uart_tx busy model (busy rises one cycle after tx_start and lasts
// FRAME cycles). Expected (grant_id, byte) pairs are queued when stimulus is
// loaded and compared whenever tx_start pulses.
`timescale 1ns/1ps
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int FRAME   = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_last  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
`ifdef UART_ARB_TIMEOUT_EN
  logic                 err_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .err_timeout (err_timeout)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx busy model
  int   busy_cnt = 0;
  logic model_en = 1'b1;
  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (model_en && tx_start === 1'b1) busy_cnt <= FRAME;
  end
  assign tx_busy = (busy_cnt != 0);

  // requester byte sources
  logic [8:0] rbuf [NUM_REQ][16];
  int         rhead [NUM_REQ] = '{default: 0};
  int         rtail [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] pend = '0;
  int         rdy_cycles [NUM_REQ] = '{default: 0};
  logic       lock_phase = 1'b0;
  int         lock_viol  = 0;

  task automatic push_req(input int r, input logic [7:0] d, input logic l);
    rbuf[r][rtail[r] % 16] = {l, d};
    rtail[r] = rtail[r] + 1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (pend[i]) rhead[i] = rhead[i] + 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = (rhead[i] != rtail[i]);
      req_data[i*8 +: 8]  = rbuf[i][rhead[i] % 16][7:0];
      req_last[i]         = rbuf[i][rhead[i] % 16][8];
    end
    #1;
    pend = req_ready;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) rdy_cycles[i] = rdy_cycles[i] + 1;
    if (|req_ready) check_eq("ready_onehot", 32'($countones(req_ready)), 32'd1);
    if (lock_phase && grant_valid && grant_id == 2'd1 && req_ready[0]) lock_viol++;
  end

  // scoreboard monitor
  logic [9:0] exp_q [$];
  logic [7:0] held_data = '0;
  logic [1:0] held_id   = '0;
  int         start_busy_viol = 0;
  int         frame_viol      = 0;

  task automatic exp_push(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (tx_start === 1'b1) begin
        if (tx_busy) start_busy_viol++;
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_start", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
          check_eq("sb_grant_id", 32'(grant_id), 32'(e[9:8]));
          check_eq("sb_grant_valid", 32'(grant_valid), 32'd1);
        end
        held_data = tx_data;
        held_id   = grant_id;
      end else if (tx_busy && grant_valid && (tx_data !== held_data || grant_id !== held_id)) begin
        frame_viol++;
      end
    end
  end

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (rhead[i] != rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #2;
      done = (exp_q.size() == 0) && !grant_valid && !tx_busy && (pend == '0) && srcs_empty();
      n++;
    end
    check_eq({tag, "_complete"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int r2;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // single request, then probe that rr_ptr landed on 2
    r2 = rdy_cycles[2];
    exp_push(2'd2, 8'h5A);
    push_req(2, 8'h5A, 1'b1);
    wait_idle("single", 200);
    check_eq("single_ready_cycles", 32'(rdy_cycles[2] - r2), 32'd1);
    exp_push(2'd3, 8'h3C);
    exp_push(2'd0, 8'hC0);
    push_req(0, 8'hC0, 1'b1);
    push_req(3, 8'h3C, 1'b1);
    wait_idle("rr_after_single", 300);

    // contention: two single-byte packets per requester
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) push_req(i, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < NUM_REQ; i++) push_req(i, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < NUM_REQ; i++) exp_push(2'(i), 8'(8'h10 + i));
    for (int i = 0; i < NUM_REQ; i++) exp_push(2'(i), 8'(8'h20 + i));
    wait_idle("contention", 800);

    // packet lock: requester 1 keeps the transmitter for three bytes
    do_reset();
    exp_push(2'd1, 8'h01);
    exp_push(2'd1, 8'h02);
    exp_push(2'd1, 8'h03);
    exp_push(2'd0, 8'h77);
    push_req(1, 8'h01, 1'b0);
    push_req(1, 8'h02, 1'b0);
    push_req(1, 8'h03, 1'b1);
    n = 0;
    while (!grant_valid && n < 50) begin @(negedge clk); #2; n++; end
    check_eq("lock_first_grant", 32'(grant_valid), 32'd1);
    push_req(0, 8'h77, 1'b1);
    lock_phase = 1'b1;
    wait_idle("packet_lock", 600);
    lock_phase = 1'b0;
    check_eq("lock_ready0_blocked", 32'(lock_viol), 32'd0);

    // reset in WAIT_DONE; transmitter still busy afterwards
    do_reset();
    exp_push(2'd1, 8'h99);
    push_req(1, 8'h99, 1'b1);
    n = 0;
    while (!tx_busy && n < 50) begin @(negedge clk); #2; n++; end
    check_eq("mid_busy_seen", 32'(tx_busy), 32'd1);
    push_req(3, 8'hA3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("mid_rst_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_eq("busy_idle_no_ready", 32'(req_ready), 32'd0);
    exp_push(2'd0, 8'hA0);
    exp_push(2'd3, 8'hA3);
    push_req(0, 8'hA0, 1'b1);
    wait_idle("after_mid_reset", 400);

`ifdef UART_ARB_TIMEOUT_EN
    // timeout: transmitter never raises busy
    do_reset();
    model_en = 1'b0;
    exp_push(2'd1, 8'h33);
    push_req(1, 8'h33, 1'b1);
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
    check_eq("tout_start_seen", 32'(tx_start), 32'd1);
    exp_push(2'd2, 8'h44);
    exp_push(2'd0, 8'h55);
    push_req(2, 8'h44, 1'b1);
    push_req(0, 8'h55, 1'b1);
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin @(negedge clk); #2; n++; end
    check_eq("tout_latency", 32'(n), 32'd16);
    check_eq("tout_grant_cleared", 32'(grant_valid), 32'd0);
    model_en = 1'b1;
    @(negedge clk); #2;
    check_eq("tout_pulse_width", 32'(err_timeout), 32'd0);
    wait_idle("after_timeout", 400);
`endif

    check_eq("start_while_busy", 32'(start_busy_viol), 32'd0);
    check_eq("frame_stability", 32'(frame_viol), 32'd0);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
